// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, constants and width clamp for the SPI peripheral
package spi_pkg;

  localparam int SPI_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    SP_IDLE,
    SP_RECV,
    SP_SEND,
    SP_DONE
  } spi_periph_state_t;

  // Requested phase widths above the shifter size are treated as a full-width phase.
  function automatic logic [6:0] clamp_width(input logic [7:0] w, input int max_w);
    if (int'(w) > max_w) begin
      return 7'(max_w);
    end
    return w[6:0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop pin synchronizer with rise/fall pulse outputs
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - oversampled SPI target: receive phase then transmit phase, MSB first
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_WIDTH   = SPI_MAX_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CPOL,
  input  logic                 CPHA,
  input  logic [7:0]           MOSI_WIDTH,
  input  logic [7:0]           MISO_WIDTH,
  input  logic [MAX_WIDTH-1:0] TX_DATA,
  output logic [MAX_WIDTH-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 TX_LOAD,
  output logic                 ABORT,
  output logic                 BUSY,
  input  logic                 CS,
  input  logic                 SCLK,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 MISO_OE
);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic cs_s_unused, sclk_s_unused;

  // CS resets low so a CS already held low at reset release never looks like a fresh fall.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
    .clk_i(CLK), .rst_ni(RESET_N), .d_i(CS),
    .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk_i(CLK), .rst_ni(RESET_N), .d_i(SCLK),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk_i(CLK), .rst_ni(RESET_N), .d_i(MOSI),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  assign cs_s_unused   = cs_s;
  assign sclk_s_unused = sclk_s;

  spi_periph_state_t    state_q, state_d;
  logic                 cpol_q, cpol_d, cpha_q, cpha_d;
  logic [6:0]           mosi_w_q, mosi_w_d, miso_w_q, miso_w_d;
  logic [6:0]           bit_cnt_q, bit_cnt_d;
  logic [MAX_WIDTH-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
  logic [MAX_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                 miso_q, miso_d;
  logic                 rx_valid_q, rx_valid_d, abort_q, abort_d;
  logic                 tx_load;

  logic                 lead, trail, sample_edge, shift_edge;
  logic [6:0]           mosi_w_in, miso_w_in, bit_cnt_inc;
  logic [MAX_WIDTH-1:0] tx_init;

  assign lead        = cpol_q ? sclk_fall : sclk_rise;
  assign trail       = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail : lead;
  assign shift_edge  = cpha_q ? lead : trail;

  assign mosi_w_in   = clamp_width(MOSI_WIDTH, MAX_WIDTH);
  assign miso_w_in   = clamp_width(MISO_WIDTH, MAX_WIDTH);
  assign bit_cnt_inc = bit_cnt_q + 7'd1;
  assign tx_init     = TX_DATA << (7'(MAX_WIDTH) - miso_w_in);

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    mosi_w_d   = mosi_w_q;
    miso_w_d   = miso_w_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    abort_d    = 1'b0;
    tx_load    = 1'b0;

    case (state_q)
      SP_IDLE: begin
        if (cs_fall) begin
          cpol_d    = CPOL;
          cpha_d    = CPHA;
          mosi_w_d  = mosi_w_in;
          miso_w_d  = miso_w_in;
          tx_load   = 1'b1;
          tx_sr_d   = tx_init;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          miso_d    = 1'b0;
          if (mosi_w_in != 7'd0) begin
            state_d = SP_RECV;
          end else if (miso_w_in != 7'd0) begin
            state_d = SP_SEND;
            // With no receive phase, mode-0 needs the first bit out before the first leading edge.
            if (!CPHA) begin
              miso_d  = tx_init[MAX_WIDTH-1];
              tx_sr_d = tx_init << 1;
            end
          end else begin
            state_d = SP_DONE;
          end
        end
      end
      SP_RECV: begin
        if (sample_edge) begin
          rx_sr_d   = {rx_sr_q[MAX_WIDTH-2:0], mosi_s};
          bit_cnt_d = bit_cnt_inc;
          if (bit_cnt_inc == mosi_w_q) begin
            rx_data_d  = rx_sr_d;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            state_d    = (miso_w_q != 7'd0) ? SP_SEND : SP_DONE;
          end
        end
      end
      SP_SEND: begin
        if (shift_edge) begin
          miso_d  = tx_sr_q[MAX_WIDTH-1];
          tx_sr_d = tx_sr_q << 1;
        end
        if (sample_edge) begin
          bit_cnt_d = bit_cnt_inc;
          if (bit_cnt_inc == miso_w_q) begin
            state_d = SP_DONE;
          end
        end
      end
      default: ;
    endcase

    // Deselect overrides any edge seen in the same cycle; a partial word is dropped.
    if (state_q != SP_IDLE && cs_rise) begin
      state_d    = SP_IDLE;
      abort_d    = (state_q == SP_RECV) || (state_q == SP_SEND);
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= SP_IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      mosi_w_q   <= '0;
      miso_w_q   <= '0;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      rx_data_q  <= '0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      mosi_w_q   <= mosi_w_d;
      miso_w_q   <= miso_w_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      rx_data_q  <= rx_data_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      abort_q    <= abort_d;
    end
  end

  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign TX_LOAD  = tx_load;
  assign ABORT    = abort_q;
  assign BUSY     = (state_q != SP_IDLE);
  assign MISO_OE  = (state_q != SP_IDLE);
  assign MISO     = (state_q == SP_SEND) & miso_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - directed vector bench for spi_peripheral with a behavioural SPI controller
module tb_spi_peripheral;

  localparam int HP = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        CPOL, CPHA;
  logic [7:0]  MOSI_WIDTH, MISO_WIDTH;
  logic [63:0] TX_DATA;
  logic [63:0] RX_DATA;
  logic        RX_VALID, TX_LOAD, ABORT, BUSY;
  logic        CS, SCLK, MOSI, MISO, MISO_OE;

  spi_peripheral dut (
    .CLK(CLK), .RESET_N(RESET_N), .CPOL(CPOL), .CPHA(CPHA),
    .MOSI_WIDTH(MOSI_WIDTH), .MISO_WIDTH(MISO_WIDTH), .TX_DATA(TX_DATA),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .TX_LOAD(TX_LOAD), .ABORT(ABORT),
    .BUSY(BUSY), .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int rxv_cnt  = 0;
  int txl_cnt  = 0;
  int abt_cnt  = 0;

  always @(negedge CLK) begin
    if (RX_VALID) rxv_cnt++;
    if (TX_LOAD)  txl_cnt++;
    if (ABORT)    abt_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Controller model: drives CS/SCLK/MOSI, samples MISO. Stops after stop_bits bits and
  // leaves CS low when the frame was cut short.
  task automatic do_frame(input logic cpol, input logic cpha, input logic [7:0] mw,
                          input logic [7:0] sw, input logic [63:0] mosi_word,
                          input int stop_bits, output logic [63:0] dout);
    int mwc, swc, total;
    mwc = (mw > 8'd64) ? 64 : int'(mw);
    swc = (sw > 8'd64) ? 64 : int'(sw);
    total = mwc + swc;
    dout = '0;
    CPOL = cpol; CPHA = cpha; MOSI_WIDTH = mw; MISO_WIDTH = sw;
    CS = 1'b1; SCLK = cpol; MOSI = 1'b0;
    cyc(2 * HP);
    CS = 1'b0;
    if (!cpha && mwc > 0) MOSI = mosi_word[mwc-1];
    for (int i = 0; i < total && i < stop_bits; i++) begin
      cyc(HP);
      if (!cpha) begin
        if (i >= mwc) dout = {dout[62:0], MISO};
        SCLK = ~cpol;
        cyc(HP);
        SCLK = cpol;
        MOSI = (i + 1 < mwc) ? mosi_word[mwc-2-i] : 1'b0;
      end else begin
        SCLK = ~cpol;
        MOSI = (i < mwc) ? mosi_word[mwc-1-i] : 1'b0;
        cyc(HP);
        if (i >= mwc) dout = {dout[62:0], MISO};
        SCLK = cpol;
      end
    end
    if (stop_bits >= total) begin
      cyc(HP);
      CS = 1'b1;
      cyc(8);
    end
  endtask

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [7:0]  mw;
    logic [7:0]  sw;
    logic [63:0] mosi;
    logic [63:0] tx;
    logic [63:0] exp_rx;
    logic [63:0] exp_dout;
    int          exp_rxv;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [63:0] dout;
    int rxv0, txl0, abt0;

    vecs[0]  = '{1'b0, 1'b0, 8'd8,   8'd8,  64'hA5,                64'h3C,                64'hA5,                64'h3C,                1};
    vecs[1]  = '{1'b0, 1'b0, 8'd16,  8'd32, 64'h1234,              64'hDEADBEEF,          64'h1234,              64'hDEADBEEF,          1};
    vecs[2]  = '{1'b0, 1'b1, 8'd16,  8'd32, 64'h1234,              64'hDEADBEEF,          64'h1234,              64'hDEADBEEF,          1};
    vecs[3]  = '{1'b1, 1'b0, 8'd16,  8'd32, 64'h1234,              64'hDEADBEEF,          64'h1234,              64'hDEADBEEF,          1};
    vecs[4]  = '{1'b1, 1'b1, 8'd16,  8'd32, 64'h1234,              64'hDEADBEEF,          64'h1234,              64'hDEADBEEF,          1};
    vecs[5]  = '{1'b0, 1'b0, 8'd0,   8'd8,  64'h0,                 64'h81,                64'h1234,              64'h81,                0};
    vecs[6]  = '{1'b1, 1'b0, 8'd64,  8'd64, 64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 1};
    vecs[7]  = '{1'b1, 1'b1, 8'd64,  8'd64, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[8]  = '{1'b0, 1'b1, 8'd200, 8'd8,  64'h0123_4567_89AB_CDEF, 64'h5A,                64'h0123_4567_89AB_CDEF, 64'h5A,                1};
    vecs[9]  = '{1'b0, 1'b1, 8'd0,   8'd16, 64'h0,                 64'hC3A5,              64'h0123_4567_89AB_CDEF, 64'hC3A5,              0};
    vecs[10] = '{1'b1, 1'b1, 8'd8,   8'd0,  64'h7E,                64'hFF,                64'h7E,                64'h0,                 1};
    vecs[11] = '{1'b0, 1'b0, 8'd8,   8'd8,  64'h01,                64'hFFFF_FF3C,         64'h01,                64'h3C,                1};

    RESET_N = 1'b0; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    CPOL = 1'b0; CPHA = 1'b0; MOSI_WIDTH = 8'd8; MISO_WIDTH = 8'd8; TX_DATA = '0;
    cyc(3);
    check("reset_rx_data", RX_DATA, 64'h0);
    check("reset_rx_valid", 64'(RX_VALID), 64'h0);
    check("reset_tx_load", 64'(TX_LOAD), 64'h0);
    check("reset_abort", 64'(ABORT), 64'h0);
    check("reset_busy", 64'(BUSY), 64'h0);
    check("reset_miso", 64'(MISO), 64'h0);
    check("reset_miso_oe", 64'(MISO_OE), 64'h0);
    RESET_N = 1'b1;
    cyc(6);

    for (int v = 0; v < 12; v++) begin
      TX_DATA = vecs[v].tx;
      rxv0 = rxv_cnt; txl0 = txl_cnt; abt0 = abt_cnt;
      do_frame(vecs[v].cpol, vecs[v].cpha, vecs[v].mw, vecs[v].sw, vecs[v].mosi, 1000, dout);
      check($sformatf("v%0d_rx_data", v), RX_DATA, vecs[v].exp_rx);
      check($sformatf("v%0d_dout", v), dout, vecs[v].exp_dout);
      check($sformatf("v%0d_rx_valid_cnt", v), 64'(rxv_cnt - rxv0), 64'(vecs[v].exp_rxv));
      check($sformatf("v%0d_tx_load_cnt", v), 64'(txl_cnt - txl0), 64'd1);
      check($sformatf("v%0d_abort_cnt", v), 64'(abt_cnt - abt0), 64'd0);
      check($sformatf("v%0d_busy_after", v), 64'(BUSY), 64'd0);
    end

    // CS raised after 3 of 8 receive bits
    TX_DATA = 64'h66;
    rxv0 = rxv_cnt; abt0 = abt_cnt;
    do_frame(1'b0, 1'b0, 8'd8, 8'd8, 64'hFF, 3, dout);
    cyc(HP);
    CS = 1'b1;
    cyc(2);
    check("abort_busy_before", 64'(BUSY), 64'd1);
    check("abort_oe_before", 64'(MISO_OE), 64'd1);
    cyc(1);
    check("abort_busy_after", 64'(BUSY), 64'd0);
    check("abort_oe_after", 64'(MISO_OE), 64'd0);
    check("abort_pulse", 64'(ABORT), 64'd1);
    cyc(4);
    check("abort_cnt", 64'(abt_cnt - abt0), 64'd1);
    check("abort_rx_kept", RX_DATA, 64'h01);
    check("abort_no_rx_valid", 64'(rxv_cnt - rxv0), 64'd0);

    // Reset mid-send with CS held low
    TX_DATA = 64'hF0;
    do_frame(1'b0, 1'b0, 8'd8, 8'd8, 64'h99, 11, dout);
    check("rst_busy_before", 64'(BUSY), 64'd1);
    check("rst_rx_before", RX_DATA, 64'h99);
    RESET_N = 1'b0;
    #1;
    check("rst_rx_data", RX_DATA, 64'h0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_miso_oe", 64'(MISO_OE), 64'd0);
    check("rst_miso", 64'(MISO), 64'd0);
    cyc(2);
    RESET_N = 1'b1;
    txl0 = txl_cnt;
    cyc(4);
    for (int k = 0; k < 4; k++) begin
      SCLK = ~SCLK;
      cyc(HP);
    end
    check("rst_no_frame_busy", 64'(BUSY), 64'd0);
    check("rst_no_frame_oe", 64'(MISO_OE), 64'd0);
    check("rst_no_tx_load", 64'(txl_cnt - txl0), 64'd0);
    CS = 1'b1;
    cyc(6);
    rxv0 = rxv_cnt;
    do_frame(1'b0, 1'b0, 8'd8, 8'd8, 64'h99, 1000, dout);
    check("rst_next_rx", RX_DATA, 64'h99);
    check("rst_next_dout", dout, 64'hF0);
    check("rst_next_tx_load", 64'(txl_cnt - txl0), 64'd1);
    check("rst_next_rx_valid", 64'(rxv_cnt - rxv0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
